// File: rtl/receiver_pkg.sv
// Shared definitions for the GMII frame receiver: state encoding, header
// layout, preamble constants and the ring free-space helper.
package receiver_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_PREAMBLE,
        RX_DATA,
        RX_HDR_WRITE,
        RX_DROP
    } rx_state_t;

    // Words reserved in front of the payload in every frame slot.
    localparam int HDR_WORDS = 7;

    localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE      = 8'hD5;

    // Header word offsets relative to the frame base; index 7 is the commit step.
    localparam logic [2:0] HDR_LEN     = 3'd0;
    localparam logic [2:0] HDR_TS3     = 3'd1;
    localparam logic [2:0] HDR_TS2     = 3'd2;
    localparam logic [2:0] HDR_TS1     = 3'd3;
    localparam logic [2:0] HDR_TS0     = 3'd4;
    localparam logic [2:0] HDR_HASH_HI = 3'd5;
    localparam logic [2:0] HDR_HASH_LO = 3'd6;
    localparam logic [2:0] HDR_COMMIT  = 3'd7;

    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB8_8320;

    // Writable words in the ring; one word is always kept unused.
    function automatic logic [13:0] ring_free(input logic [13:0] rd_ptr,
                                              input logic [13:0] wr_ptr);
        return rd_ptr - wr_ptr - 14'd1;
    endfunction

endpackage

// File: rtl/receiver_if.sv
// Slot memory write port plus the producer/consumer ring pointers.
interface receiver_if;
    logic [15:0] slot_rx_eth_data;
    logic [1:0]  slot_rx_eth_byte_en;
    logic [13:0] slot_rx_eth_addr;
    logic        slot_rx_eth_wr_en;
    logic [13:0] mem_wr_ptr;
    logic [13:0] mem_rd_ptr;

    modport master (
        output slot_rx_eth_data, slot_rx_eth_byte_en, slot_rx_eth_addr,
               slot_rx_eth_wr_en, mem_wr_ptr,
        input  mem_rd_ptr
    );

    modport slave (
        input  slot_rx_eth_data, slot_rx_eth_byte_en, slot_rx_eth_addr,
               slot_rx_eth_wr_en, mem_wr_ptr,
        output mem_rd_ptr
    );
endinterface

// File: rtl/receiver_rx_crc32.sv
// Byte-wide Ethernet CRC-32. The register runs in reflected (LSB-first) form,
// so its complement already has the first wire byte in bits [7:0] and can be
// compared directly against the FCS as assembled from the wire.
module rx_crc32
    import receiver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] crc_q;
    logic [31:0] crc_d;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  byte_in);
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ byte_in[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else                   c = c >> 1;
        end
        return c;
    endfunction

    // Next CRC value: restart on init, fold in one byte when enabled.
    always_comb begin
        crc_d = crc_q;
        if (init)    crc_d = CRC_INIT;
        else if (en) crc_d = crc_byte(crc_q, data);
    end

    // CRC state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) crc_q <= CRC_INIT;
        else     crc_q <= crc_d;
    end

    assign crc_out = ~crc_q;

endmodule

// File: rtl/receiver.sv
// GMII receiver: strips preamble/SFD, timestamps the frame, streams payload
// bytes into the slot ring, verifies the FCS and commits good frames by
// writing a 7-word header before advancing mem_wr_ptr.
module receiver
    import receiver_pkg::*;
#(
    parameter int MIN_LEN = 60,
    parameter int MAX_LEN = 1514
) (
    input  logic              gmii_rx_clk,
    input  logic              sys_rst,
    input  logic [63:0]       global_counter,
    input  logic [7:0]        gmii_rxd,
    input  logic              gmii_rx_dv,
    input  logic              gmii_rx_er,
    receiver_if.master        slot,
    output logic [31:0]       rx_frame_cnt,
    output logic [31:0]       rx_drop_cnt
);

    localparam logic [15:0] MIN_LEN_W = 16'(MIN_LEN);
    localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

    rx_state_t   state_q, state_d;
    logic [63:0] ts_q, ts_d;
    logic [13:0] base_q, base_d;
    logic [13:0] free_q, free_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [31:0] dl_q, dl_d;
    logic [2:0]  dl_cnt_q, dl_cnt_d;
    logic [2:0]  hdr_idx_q, hdr_idx_d;
    logic        dv_seen_q, dv_seen_d;
    logic [15:0] data_q, data_d;
    logic [1:0]  be_q, be_d;
    logic [13:0] addr_q, addr_d;
    logic        wr_en_q, wr_en_d;
    logic [13:0] wr_ptr_q, wr_ptr_d;
    logic [31:0] frame_cnt_q, frame_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    logic        crc_init, crc_en;
    logic [31:0] crc_fcs;
    logic [13:0] sfd_free;
    logic [13:0] wr_offset;
    logic [13:0] commit_ptr;
    logic        frame_good;

    rx_crc32 u_crc (
        .clk     (gmii_rx_clk),
        .rst     (sys_rst),
        .init    (crc_init),
        .en      (crc_en),
        .data    (dl_q[7:0]),
        .crc_out (crc_fcs)
    );

    assign sfd_free   = ring_free(slot.mem_rd_ptr, wr_ptr_q);
    assign wr_offset  = 14'(HDR_WORDS) + byte_cnt_q[14:1];
    assign commit_ptr = base_q + 14'(HDR_WORDS) + byte_cnt_q[14:1]
                        + {13'd0, byte_cnt_q[0]};
    // With dv low the delay line holds exactly the FCS bytes, LSB first.
    assign frame_good = (dl_cnt_q == 3'd4) && (crc_fcs == dl_q) &&
                        (byte_cnt_q >= MIN_LEN_W) && (byte_cnt_q <= MAX_LEN_W);

    // Receive state machine: framing, payload streaming, header write and commit.
    always_comb begin
        state_d     = state_q;
        ts_d        = ts_q;
        base_d      = base_q;
        free_d      = free_q;
        byte_cnt_d  = byte_cnt_q;
        dl_d        = dl_q;
        dl_cnt_d    = dl_cnt_q;
        hdr_idx_d   = hdr_idx_q;
        dv_seen_d   = dv_seen_q;
        data_d      = data_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wr_en_d     = 1'b0;
        wr_ptr_d    = wr_ptr_q;
        frame_cnt_d = frame_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        crc_init    = 1'b0;
        crc_en      = 1'b0;

        case (state_q)
            RX_IDLE, RX_PREAMBLE: begin
                if (!gmii_rx_dv) begin
                    state_d = RX_IDLE;
                end else if (gmii_rxd == PREAMBLE_BYTE) begin
                    state_d = RX_PREAMBLE;
                end else if (gmii_rxd == SFD_BYTE) begin
                    ts_d       = global_counter;
                    base_d     = wr_ptr_q;
                    free_d     = sfd_free;
                    byte_cnt_d = 16'd0;
                    dl_d       = 32'd0;
                    dl_cnt_d   = 3'd0;
                    crc_init   = 1'b1;
                    if (sfd_free < 14'(HDR_WORDS + 1)) begin
                        state_d    = RX_DROP;
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end else begin
                        state_d = RX_DATA;
                    end
                end else begin
                    state_d    = RX_DROP;
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end
            end

            RX_DATA: begin
                if (!gmii_rx_dv) begin
                    if (frame_good) begin
                        state_d   = RX_HDR_WRITE;
                        hdr_idx_d = HDR_LEN;
                        dv_seen_d = 1'b0;
                    end else begin
                        state_d    = RX_IDLE;
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                end else if (gmii_rx_er) begin
                    state_d    = RX_DROP;
                    drop_cnt_d = drop_cnt_q + 32'd1;
                end else begin
                    dl_d = {gmii_rxd, dl_q[31:8]};
                    if (dl_cnt_q != 3'd4) begin
                        dl_cnt_d = dl_cnt_q + 3'd1;
                    end else if (byte_cnt_q >= MAX_LEN_W || wr_offset >= free_q) begin
                        state_d    = RX_DROP;
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end else begin
                        crc_en     = 1'b1;
                        wr_en_d    = 1'b1;
                        addr_d     = base_q + wr_offset;
                        data_d     = byte_cnt_q[0] ? {8'h00, dl_q[7:0]} : {dl_q[7:0], 8'h00};
                        be_d       = byte_cnt_q[0] ? 2'b01 : 2'b10;
                        byte_cnt_d = byte_cnt_q + 16'd1;
                    end
                end
            end

            RX_HDR_WRITE: begin
                if (gmii_rx_dv) dv_seen_d = 1'b1;
                if (hdr_idx_q != HDR_COMMIT) begin
                    wr_en_d   = 1'b1;
                    be_d      = 2'b11;
                    addr_d    = base_q + {11'd0, hdr_idx_q};
                    hdr_idx_d = hdr_idx_q + 3'd1;
                    case (hdr_idx_q)
                        HDR_LEN:     data_d = byte_cnt_q;
                        HDR_TS3:     data_d = ts_q[63:48];
                        HDR_TS2:     data_d = ts_q[47:32];
                        HDR_TS1:     data_d = ts_q[31:16];
                        HDR_TS0:     data_d = ts_q[15:0];
                        HDR_HASH_HI: data_d = dl_q[31:16];
                        HDR_HASH_LO: data_d = dl_q[15:0];
                        default:     data_d = 16'h0000;
                    endcase
                end else begin
                    wr_ptr_d    = commit_ptr;
                    frame_cnt_d = frame_cnt_q + 32'd1;
                    if (dv_seen_q || gmii_rx_dv) begin
                        state_d    = RX_DROP;
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end else begin
                        state_d = RX_IDLE;
                    end
                end
            end

            RX_DROP: begin
                if (!gmii_rx_dv) state_d = RX_IDLE;
            end

            default: state_d = RX_IDLE;
        endcase
    end

    // State and registered outputs; reset abandons any partial frame.
    always_ff @(posedge gmii_rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= RX_IDLE;
            ts_q        <= 64'd0;
            base_q      <= 14'd0;
            free_q      <= 14'd0;
            byte_cnt_q  <= 16'd0;
            dl_q        <= 32'd0;
            dl_cnt_q    <= 3'd0;
            hdr_idx_q   <= 3'd0;
            dv_seen_q   <= 1'b0;
            data_q      <= 16'd0;
            be_q        <= 2'b00;
            addr_q      <= 14'd0;
            wr_en_q     <= 1'b0;
            wr_ptr_q    <= 14'd0;
            frame_cnt_q <= 32'd0;
            drop_cnt_q  <= 32'd0;
        end else begin
            state_q     <= state_d;
            ts_q        <= ts_d;
            base_q      <= base_d;
            free_q      <= free_d;
            byte_cnt_q  <= byte_cnt_d;
            dl_q        <= dl_d;
            dl_cnt_q    <= dl_cnt_d;
            hdr_idx_q   <= hdr_idx_d;
            dv_seen_q   <= dv_seen_d;
            data_q      <= data_d;
            be_q        <= be_d;
            addr_q      <= addr_d;
            wr_en_q     <= wr_en_d;
            wr_ptr_q    <= wr_ptr_d;
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign slot.slot_rx_eth_data    = data_q;
    assign slot.slot_rx_eth_byte_en = be_q;
    assign slot.slot_rx_eth_addr    = addr_q;
    assign slot.slot_rx_eth_wr_en   = wr_en_q;
    assign slot.mem_wr_ptr          = wr_ptr_q;
    assign rx_frame_cnt             = frame_cnt_q;
    assign rx_drop_cnt              = drop_cnt_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for the GMII receiver: a frame-level reference model
// predicts every slot write and pointer commit; a monitor checks them.
module tb_receiver;

    typedef logic [7:0] bq_t [$];
    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
        logic [1:0]  be;
    } wr_t;

    localparam int HDR     = 7;
    localparam int MINLEN  = 60;
    localparam int MAXLEN  = 1514;
    localparam int RING    = 16384;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] gc;
    logic [7:0]  rxd;
    logic        dv;
    logic        er;
    logic [31:0] rx_frame_cnt;
    logic [31:0] rx_drop_cnt;

    receiver_if rif ();

    receiver dut (
        .gmii_rx_clk    (clk),
        .sys_rst        (rst),
        .global_counter (gc),
        .gmii_rxd       (rxd),
        .gmii_rx_dv     (dv),
        .gmii_rx_er     (er),
        .slot           (rif),
        .rx_frame_cnt   (rx_frame_cnt),
        .rx_drop_cnt    (rx_drop_cnt)
    );

    always #5 clk = ~clk;

    wr_t         exp_wr_q [$];
    logic [13:0] exp_ptr_q [$];
    logic [13:0] m_wr_ptr;
    logic [31:0] m_frames;
    logic [31:0] m_drops;
    int          checks = 0;
    int          passed = 0;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual === expected) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    // Ethernet CRC computed MSB-first with the normal polynomial over the
    // wire bit order, then reflected and complemented into FCS byte order.
    function automatic logic [31:0] crcRef(input bq_t p);
        logic [31:0] c;
        logic [31:0] r;
        logic        fb;
        c = 32'hFFFF_FFFF;
        foreach (p[j]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[31] ^ p[j][i];
                c  = {c[30:0], 1'b0};
                if (fb) c = c ^ 32'h04C1_1DB7;
            end
        end
        for (int i = 0; i < 32; i++) r[i] = c[31 - i];
        return ~r;
    endfunction

    function automatic bq_t makeFrame(input int n, input bit corrupt);
        bq_t         f;
        logic [31:0] fcs;
        for (int i = 0; i < n; i++) f.push_back(8'($urandom));
        fcs = crcRef(f);
        for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
        if (corrupt) f[f.size() - 1] = f[f.size() - 1] ^ 8'hFF;
        return f;
    endfunction

    // Frame-level prediction of writes, commit pointer and counters.
    task automatic modelFrame(input bq_t body, input int err_idx,
                              input logic [63:0] ts, input logic [13:0] rd);
        int          base, free, m, stop, n;
        logic [31:0] fcs;
        logic [15:0] hdr [7];
        bq_t         pay;
        wr_t         w;
        base = int'(m_wr_ptr);
        free = (int'(rd) - base - 1 + RING) % RING;
        if (free < HDR + 1) begin m_drops = m_drops + 1; return; end
        m    = body.size();
        stop = (err_idx >= 0) ? err_idx : m;
        for (int k = 0; k + 4 < stop; k++) begin
            if (k >= MAXLEN || HDR + k / 2 >= free) begin m_drops = m_drops + 1; return; end
            w.addr = 14'((base + HDR + k / 2) % RING);
            w.data = (k % 2 == 0) ? {body[k], 8'h00} : {8'h00, body[k]};
            w.be   = (k % 2 == 0) ? 2'b10 : 2'b01;
            exp_wr_q.push_back(w);
        end
        if (err_idx >= 0 || m < 4) begin m_drops = m_drops + 1; return; end
        n = m - 4;
        for (int i = 0; i < n; i++) pay.push_back(body[i]);
        fcs = {body[m-1], body[m-2], body[m-3], body[m-4]};
        if (crcRef(pay) != fcs || n < MINLEN || n > MAXLEN) begin
            m_drops = m_drops + 1;
            return;
        end
        hdr[0] = 16'(n);       hdr[1] = ts[63:48]; hdr[2] = ts[47:32];
        hdr[3] = ts[31:16];    hdr[4] = ts[15:0];  hdr[5] = fcs[31:16];
        hdr[6] = fcs[15:0];
        for (int i = 0; i < HDR; i++) begin
            w.addr = 14'((base + i) % RING);
            w.data = hdr[i];
            w.be   = 2'b11;
            exp_wr_q.push_back(w);
        end
        m_wr_ptr = 14'((base + HDR + (n + 1) / 2) % RING);
        exp_ptr_q.push_back(m_wr_ptr);
        m_frames = m_frames + 1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic e);
        dv  = v;
        rxd = d;
        er  = e;
        @(posedge clk);
        #1;
        gc = gc + 64'd1;
    endtask

    task automatic applyStimulus(input bq_t body, input int err_idx,
                                 input logic [13:0] rd, input int ifg);
        rif.mem_rd_ptr = rd;
        repeat (7) drive(1'b1, 8'h55, 1'b0);
        modelFrame(body, err_idx, gc, rd);
        drive(1'b1, 8'hD5, 1'b0);
        foreach (body[i]) drive(1'b1, body[i], (i == err_idx));
        repeat (ifg) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic checkCounters(input string name);
        repeat (4) drive(1'b0, 8'h00, 1'b0);
        checkOutput({name, "_frames"}, 64'(rx_frame_cnt), 64'(m_frames));
        checkOutput({name, "_drops"}, 64'(rx_drop_cnt), 64'(m_drops));
        checkOutput({name, "_wr_ptr"}, 64'(rif.mem_wr_ptr), 64'(m_wr_ptr));
        checkOutput({name, "_pending_writes"}, 64'(exp_wr_q.size()), 64'd0);
        checkOutput({name, "_pending_commits"}, 64'(exp_ptr_q.size()), 64'd0);
    endtask

    task automatic doReset();
        rst = 1'b1;
        repeat (2) drive(1'b0, 8'h00, 1'b0);
        rst      = 1'b0;
        m_wr_ptr = 14'd0;
        m_frames = 32'd0;
        m_drops  = 32'd0;
        exp_wr_q.delete();
        exp_ptr_q.delete();
        drive(1'b0, 8'h00, 1'b0);
    endtask

    // Monitor: every write and every pointer move is matched against the model.
    logic [13:0] prev_ptr = 14'd0;
    wr_t         mon_e;
    always @(negedge clk) begin
        if (rst) begin
            prev_ptr = 14'd0;
        end else begin
            if (rif.slot_rx_eth_wr_en) begin
                if (exp_wr_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_write: got addr 0x%0h data 0x%0h be %b, expected no write",
                             rif.slot_rx_eth_addr, rif.slot_rx_eth_data, rif.slot_rx_eth_byte_en);
                end else begin
                    mon_e = exp_wr_q.pop_front();
                    checkOutput("slot_write",
                                64'({rif.slot_rx_eth_addr, rif.slot_rx_eth_data, rif.slot_rx_eth_byte_en}),
                                64'(mon_e));
                end
            end
            if (rif.mem_wr_ptr != prev_ptr) begin
                checkOutput("header_before_commit", 64'(exp_wr_q.size()), 64'd0);
                if (exp_ptr_q.size() == 0) begin
                    checks++;
                    $display("[TB] FAIL unexpected_commit: got mem_wr_ptr 0x%0h, expected 0x%0h",
                             rif.mem_wr_ptr, prev_ptr);
                end else begin
                    checkOutput("mem_wr_ptr", 64'(rif.mem_wr_ptr), 64'(exp_ptr_q.pop_front()));
                end
                prev_ptr = rif.mem_wr_ptr;
            end
        end
    end

    bq_t f;
    int  n, e, rem, delta;
    bit  bad;

    initial begin
        rst = 1'b1; dv = 1'b0; er = 1'b0; rxd = 8'h00; gc = 64'd0;
        rif.mem_rd_ptr = 14'd0;
        m_wr_ptr = 14'd0; m_frames = 32'd0; m_drops = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_wr_ptr", 64'(rif.mem_wr_ptr), 64'd0);
        checkOutput("reset_wr_en", 64'(rif.slot_rx_eth_wr_en), 64'd0);
        checkOutput("reset_addr_data", 64'({rif.slot_rx_eth_addr, rif.slot_rx_eth_data}), 64'd0);
        checkOutput("reset_counters", {rx_frame_cnt, rx_drop_cnt}, 64'd0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0);

        $display("[TB] good 60-byte frame, timestamp 0x1234");
        f  = makeFrame(60, 1'b0);
        gc = 64'h1234 - 64'd7;
        applyStimulus(f, -1, 14'd0, 12);
        checkCounters("good60");
        checkOutput("good60_ptr_value", 64'(rif.mem_wr_ptr), 64'd37);
        checkOutput("good60_frames_value", 64'(rx_frame_cnt), 64'd1);

        $display("[TB] same frame with corrupted FCS");
        doReset();
        f[f.size() - 1] = f[f.size() - 1] ^ 8'h01;
        applyStimulus(f, -1, 14'd0, 12);
        checkCounters("badfcs");
        checkOutput("badfcs_drops_value", 64'(rx_drop_cnt), 64'd1);
        checkOutput("badfcs_ptr_value", 64'(rif.mem_wr_ptr), 64'd0);

        $display("[TB] rx_er at payload byte 20, then a good frame");
        applyStimulus(makeFrame(80, 1'b0), 20, m_wr_ptr + 14'd0, 12);
        checkCounters("rxer");
        applyStimulus(makeFrame(60, 1'b0), -1, m_wr_ptr, 12);
        checkCounters("after_rxer");

        $display("[TB] ring full during payload");
        doReset();
        applyStimulus(makeFrame(100, 1'b0), -1, 14'd40, 12);
        checkCounters("full");
        checkOutput("full_ptr_value", 64'(rif.mem_wr_ptr), 64'd0);

        $display("[TB] no header space at SFD, length limits");
        applyStimulus(makeFrame(60, 1'b0), -1, m_wr_ptr + 14'd8, 12);
        applyStimulus(makeFrame(59, 1'b0), -1, m_wr_ptr, 12);
        applyStimulus(makeFrame(MAXLEN + 1, 1'b0), -1, m_wr_ptr, 12);
        checkCounters("limits");

        $display("[TB] randomized frames");
        gc = {$urandom, $urandom};
        for (int t = 0; t < 8; t++) begin
            n   = int'($urandom_range(300, 30));
            bad = ($urandom_range(3, 0) == 0);
            e   = ($urandom_range(4, 0) == 0) ? int'($urandom_range(n + 3, 0)) : -1;
            applyStimulus(makeFrame(n, bad), e, m_wr_ptr, 12);
        end
        checkCounters("random");

        $display("[TB] back-to-back 64-byte frames");
        doReset();
        applyStimulus(makeFrame(64, 1'b0), -1, 14'd0, 12);
        applyStimulus(makeFrame(64, 1'b0), -1, 14'd0, 12);
        checkCounters("b2b");
        checkOutput("b2b_frames_value", 64'(rx_frame_cnt), 64'd2);
        checkOutput("b2b_ptr_value", 64'(rif.mem_wr_ptr), 64'd78);

        $display("[TB] filling ring up to 0x3FF0, then wrap frame");
        doReset();
        while (m_wr_ptr != 14'h3FF0) begin
            rem = 16'h3FF0 - int'(m_wr_ptr);
            if (rem >= 764 + 37) delta = 764;
            else if (rem <= 764) delta = rem;
            else                 delta = rem - 37;
            applyStimulus(makeFrame(2 * (delta - HDR), 1'b0), -1, m_wr_ptr, 12);
        end
        checkCounters("fill");
        applyStimulus(makeFrame(61, 1'b0), -1, 14'h0100, 12);
        checkCounters("wrap");
        checkOutput("wrap_ptr_value", 64'(rif.mem_wr_ptr), 64'h0016);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/receiver.md
Name: receiver

Overview:
- GMII receive-side counterpart of the TX frame slot sender.
- Strips the preamble/SFD, timestamps each frame at the SFD from global_counter, writes the payload into the RX frame slot memory and checks the Ethernet FCS.
- Commits a good frame by writing a 7-word header and then advancing mem_wr_ptr.
- Slot layout per frame (16-bit words) matches what the sender consumes: frame_len, timestamp[63:48..15:0], hash[31:16], hash[15:0], then payload.

Parameters:
MIN_LEN, 60, minimum payload bytes excluding FCS; shorter frames are dropped.
MAX_LEN, 1514, maximum payload bytes excluding FCS; longer frames are dropped.
HDR_WORDS, 7, header words reserved ahead of the payload.

Ports:
gmii_rx_clk  in  1  receive clock; sole clock.
sys_rst  in  1  reset, asynchronous, active-high.
global_counter  in  64  free-running time base.
gmii_rxd  in  8  GMII receive data.
gmii_rx_dv  in  1  GMII data valid.
gmii_rx_er  in  1  GMII receive error.
slot_rx_eth_data  out  16  write data.
slot_rx_eth_byte_en  out  2  byte enables; bit1 = [15:8].
slot_rx_eth_addr  out  14  word address.
slot_rx_eth_wr_en  out  1  write strobe.
mem_wr_ptr  out  14  committed write pointer (one past the last committed word).
mem_rd_ptr  in  14  consumer read pointer.
rx_frame_cnt  out  32  frames committed.
rx_drop_cnt  out  32  frames discarded for any reason.

Behaviour:
- Reset: all outputs registered and cleared to 0. The state machine returns to RX_IDLE and any partial frame is lost; the consumer resets mem_rd_ptr.
- States:
  - RX_IDLE:
    - dv=1 and rxd=0x55 -> RX_PREAMBLE.
    - dv=1 and rxd=0xD5 -> RX_DATA (SFD taken).
    - Any other dv=1 byte -> RX_DROP.
  - RX_PREAMBLE:
    - 0x55 -> stay.
    - 0xD5 -> RX_DATA.
    - dv=0 -> RX_IDLE, no count.
    - Other byte -> RX_DROP.
  - SFD cycle:
    - Latch ts <= global_counter.
    - base <= mem_wr_ptr.
    - Clear the byte count and the 4-byte delay line.
    - Initialise CRC-32 to all-ones.
    - Free space free = (mem_rd_ptr - mem_wr_ptr - 1) mod 2^14. If free < HDR_WORDS+1 -> RX_DROP.
  - RX_DATA:
    - Each dv=1 byte enters a 4-byte delay line.
    - Once the line is full, the byte leaving it is payload byte n. It feeds the CRC and is written immediately:
      - addr = base + 7 + n>>1.
      - n even: data {b,8'h00}, byte_en 2'b10.
      - n odd: data {8'h00,b}, byte_en 2'b01.
      - One write per payload byte.
    - Write legality: ((addr - base) mod 2^14) < free. An illegal write is suppressed and -> RX_DROP.
    - rx_er=1 with dv=1 -> RX_DROP.
    - n reaching MAX_LEN+1 -> RX_DROP.
    - dv=0: the delay line holds the FCS (first-received byte is the FCS LSB, per IEEE 802.3).
      - Good frame -> RX_HDR_WRITE. Good means complemented, bit-reflected CRC == FCS and MIN_LEN <= n <= MAX_LEN.
      - Otherwise rx_drop_cnt+1 -> RX_IDLE.
  - RX_HDR_WRITE:
    - 7 consecutive cycles, byte_en 2'b11, addr base+0 .. base+6.
    - Data in order: len, ts[63:48], ts[47:32], ts[31:16], ts[15:0], crc[31:16], crc[15:0]. crc is the received FCS value and serves as the frame hash.
    - Cycle after the word-6 write:
      - mem_wr_ptr <= base + 7 + ceil(len/2), mod 2^14.
      - rx_frame_cnt+1.
      - -> RX_IDLE.
    - dv rising during RX_HDR_WRITE: that frame is ignored. After the header completes -> RX_DROP until dv=0, counted as a drop.
  - RX_DROP: wait for dv=0. rx_drop_cnt increments once per dropped frame, on entry. Then -> RX_IDLE.
- Commit semantics:
  - mem_wr_ptr never moves on a dropped frame; partially written words are overwritten by the next frame.
  - The header is always written before the pointer advances.
- Addressing:
  - All address arithmetic is 14-bit wrap-around.
  - The ring is empty when mem_rd_ptr == mem_wr_ptr; one word always stays unused.
- Minimum IFG of 12 plus 8 preamble bytes covers the 7 header cycles.
- wr_en is asserted only in RX_DATA (legal payload writes) and RX_HDR_WRITE.
- Counters wrap at 2^32.

Decomposition:
- Shared package:
  - State encoding (RX_IDLE, RX_PREAMBLE, RX_DATA, RX_HDR_WRITE, RX_DROP).
  - Header word offsets (0 = len … 6 = hash low).
  - Preamble/SFD constants 0x55/0xD5.
  - HDR_WORDS.
- Sub-module rx_crc32: byte-wide CRC-32 with init/enable, output complemented and bit-reflected for direct compare with the received FCS.

Test Plan:
- 60-byte payload plus correct FCS, global_counter=0x1234 at SFD, mem_wr_ptr=0, mem_rd_ptr=0:
  - Header words 0x003C, 0x0000, 0x0000, 0x0000, 0x1234, FCS hi, FCS lo.
  - Payload at words 7..36.
  - mem_wr_ptr=37, rx_frame_cnt=1.
- Same frame with the last FCS byte flipped -> no header write, mem_wr_ptr stays 0, rx_drop_cnt=1.
- rx_er pulsed at payload byte 20 -> RX_DROP, mem_wr_ptr unchanged, one drop counted, next good frame commits normally.
- mem_rd_ptr=40, mem_wr_ptr=0, 100-byte frame (needs 57 words) -> write suppressed at word 39, drop counted, mem_wr_ptr=0.
- Wrap: mem_wr_ptr=0x3FF0, mem_rd_ptr=0x0100, 61-byte frame:
  - Header at 0x3FF0..0x3FF6.
  - Payload wraps through 0x0000.
  - mem_wr_ptr=0x0016.
  - Last word byte_en 2'b10.
- Two good 64-byte frames with 12-byte IFG -> both committed, rx_frame_cnt=2, second base = first end pointer.
